// File: rtl/vna_sample_mux_pkg.sv
// Shared radio package for the VNA sample mux.
//   IDX_W    : scan index width, matches vna_count
//   tag_t    : per-entry tag {first, idx}; a FIFO entry is {tag_t, I, Q}
//   next_idx : scan index step, wraps to 0 once idx reaches the point count
package vna_sample_mux_pkg;

    localparam int unsigned IDX_W = 16;

    typedef struct packed {
        logic             first;
        logic [IDX_W-1:0] idx;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

    // One scan is count+1 points: the zero sample plus count points.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [IDX_W-1:0] count);
        return (idx >= count) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/vna_sample_mux_sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with synchronous flush.
//   clock, reset_n : system clock, synchronous active-low reset
//   flush          : clears pointers and count; push/pop ignored that cycle
//   push, din      : write one entry (caller guarantees not full or popping)
//   pop            : consume head (caller guarantees not empty)
//   dout           : head entry at the read pointer
//   full, empty    : occupancy flags
//   level          : entry count, 0..DEPTH
module sample_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the head is qualified by empty downstream.
    always_ff @(posedge clock) begin
        if (reset_n && !flush && push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/vna_sample_mux.sv
// vna_sample_mux: selects receiver samples or strobed VNA scanner points,
// tags scanner points with their scan index and queues them for the packetizer.
//   clock, reset_n           : system clock, synchronous active-low reset
//   vna, vna_count           : mode; scanner source when vna && vna_count != 0
//   vna_strobe, vna_I/Q      : scanner point
//   rx_strobe, rx_I/Q        : receiver sample
//   out_valid/ready, out_I/Q : valid/ready head of the FIFO
//   out_index, out_first     : scan index of head, first marks index 0 scanner point
//   level                    : FIFO occupancy
//   overflow, clear_overflow : sticky drop flag and its clear
module vna_sample_mux
    import vna_sample_mux_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 24
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     vna,
    input  logic [IDX_W-1:0]         vna_count,
    input  logic                     vna_strobe,
    input  logic signed [W-1:0]      vna_I,
    input  logic signed [W-1:0]      vna_Q,
    input  logic                     rx_strobe,
    input  logic signed [W-1:0]      rx_I,
    input  logic signed [W-1:0]      rx_Q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [W-1:0]      out_I,
    output logic signed [W-1:0]      out_Q,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_first,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int unsigned EW = TAG_W + 2*W;

    logic             sel;
    logic             sel_q;
    logic             flush;
    logic             strobe;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [IDX_W-1:0] idx;
    tag_t             in_tag;
    tag_t             head_tag;
    logic [EW-1:0]    din;
    logic [EW-1:0]    head;

    assign sel    = vna && (vna_count != '0);
    assign flush  = (sel != sel_q);
    assign strobe = sel ? vna_strobe : rx_strobe;

    // out_valid depends only on state and mode, never on out_ready.
    assign out_valid = !empty && !flush;
    assign pop       = out_valid && out_ready;
    assign push      = strobe && !flush && (!full || pop);
    assign drop      = strobe && !flush && full && !pop;

    always_comb begin
        in_tag       = '0;
        in_tag.first = sel && (idx == '0);
        in_tag.idx   = sel ? idx : '0;
        din          = sel ? {in_tag, vna_I, vna_Q} : {in_tag, rx_I, rx_Q};
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sel_q    <= 1'b0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            sel_q <= sel;
            // Index steps on every scanner strobe, accepted or dropped.
            if (flush)
                idx <= '0;
            else if (sel && vna_strobe)
                idx <= next_idx(idx, vna_count);
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    always_comb begin
        head_tag  = tag_t'(head[EW-1 -: TAG_W]);
        out_I     = '0;
        out_Q     = '0;
        out_index = '0;
        out_first = 1'b0;
        if (out_valid) begin
            out_I     = head[2*W-1 -: W];
            out_Q     = head[W-1:0];
            out_index = head_tag.idx;
            out_first = head_tag.first;
        end
    end

endmodule

// File: doc/vna_sample_mux.md
# vna_sample_mux

Selects between the normal receiver sample stream and the VNA scanner's strobed averaged I/Q points, tags each VNA point with its scan index, and buffers the selected stream in a small FIFO. Sits directly downstream of the VNA scanner and the receiver decimator, and upstream of the Ethernet/USB packetizer, which drains it through a valid/ready handshake.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 4.
- `W`, 24: sample width of I and Q.

- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `vna`  in  1  VNA mode, for either FPGA scan or PC scan.
- `vna_count`  in  16  points per FPGA scan; 0 means PC scan.
- `vna_strobe`  in  1  one-cycle pulse: a scanner point is valid.
- `vna_I`, `vna_Q`  in  W each  signed scanner point.
- `rx_strobe`  in  1  one-cycle pulse: a receiver sample is valid.
- `rx_I`, `rx_Q`  in  W each  signed receiver sample.
- `out_valid`  out  1  the FIFO head is presented.
- `out_ready`  in  1  the consumer accepts the head.
- `out_I`, `out_Q`  out  W each  head sample.
- `out_index`  out  16  scan point index; 0 marks the scan-start zero sample.
- `out_first`  out  1  high when `out_index` is 0 and the head is a scanner point.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a sample was dropped.
- `clear_overflow`  in  1  clears `overflow`.

## Operation
- **Source select:**
  - `sel` = `vna` && (`vna_count` != 0).
  - `sel` = 1 takes the scanner source; `sel` = 0 takes the receiver source (PC scan uses the normal receiver).
  - The strobe and data of the unselected source are ignored.
- **Mode register:** `sel_q` is registered every cycle.
- **Flush:** a flush cycle occurs whenever `sel` != `sel_q`. In a flush cycle:
  - the read pointer, write pointer and count are cleared;
  - `idx` is cleared to 0;
  - any push or pop is ignored;
  - `out_valid` is forced to 0.
- **Push:** the selected strobe writes one entry {first, idx, I, Q}.
  - For the receiver source, first=0 and idx=0.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - If neither holds, the sample is dropped and `overflow` is set.
- **Index counter** (scanner source only):
  - Steps on every scanner strobe, whether the point is accepted or dropped, so indices stay aligned with the scan.
  - Next value: if `idx` >= `vna_count` then 0, else `idx`+1. One scan is therefore `vna_count`+1 points (zero sample plus `vna_count` points).
  - A change of `vna_count` from one nonzero value to another takes effect at the next compare; no flush occurs.
- **Pop:** `out_valid` && `out_ready`. The head is first-word-fall-through from the FIFO memory at the read pointer.
- **Output gating:** when `out_valid` = 0, `out_I`, `out_Q`, `out_index` and `out_first` are driven to 0.
- **`overflow`:**
  - `clear_overflow` clears it.
  - If a drop and `clear_overflow` occur in the same cycle, the drop wins and `overflow` stays 1.
- **Pointers:** wrap modulo `DEPTH`. `level` equals the entry count, from 0 to `DEPTH`.

## Timing
- **Reset values:**
  - pointers, count, `idx`, `overflow` = 0;
  - `sel_q` = 0;
  - all outputs are 0.
- **Push latency:** a push in cycle n presents its entry at the head in cycle n+1 if the FIFO was empty (`out_valid` rises in n+1).
- **`level`:** registered; updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- **Handshake:**
  - The head, `out_valid` and the output data stay stable until popped, except in a flush cycle.
  - `out_valid` never depends combinationally on `out_ready`.
- **Flush timing:** a flush cycle is the cycle in which `sel` first differs from `sel_q`. Normal operation resumes the next cycle.
- **Reset mid-stream:** `reset_n` low clears everything on the next rising edge, regardless of strobes or `out_ready`.
- **Strobes:** assumed single-cycle and at least 2 cycles apart. Both source strobes high together is legal; only the selected one is used.

## Structure
- **Shared package:** the entry record type {first, idx[15:0], I[W-1:0], Q[W-1:0]} and the index width constant (16, matching `vna_count`) go in the shared radio package.
- **Sub-module `sample_fifo`:** parameterised `DEPTH`×width, first-word-fall-through, with a synchronous flush input and full/empty/level outputs. The top level holds source select, the flush detect, the index counter and the overflow logic.

## Test plan
- **Receiver passthrough:** `vna`=0; 5 `rx_strobe` with I=1..5, `out_ready`=1 -> 5 outputs I=1..5, `out_index`=0, `out_first`=0, `level` returns to 0.
- **FPGA scan tagging:** `vna`=1, `vna_count`=3; 9 scanner strobes -> `out_index` sequence 0,1,2,3,0,1,2,3,0; `out_first` high on entries 1, 5 and 9.
- **Overflow:** `DEPTH`=16, `out_ready`=0, 18 strobes -> `level`=16 and `overflow`=1; output holds the first 16 samples in order. With `out_ready`=1 on the next strobe while full, that strobe is accepted and `level` stays 16.
- **Mode flush:** 6 entries queued; drop `vna_count` to 0 -> one cycle later `out_valid`=0 and `level`=0; the next `rx_strobe` outputs with `out_index`=0.
- **Reset mid-stream:** queue 4 entries, pulse `reset_n` low for 1 cycle while a strobe arrives -> all outputs and `level` are 0 and the strobe is lost. Then set and clear `overflow` with `clear_overflow` in the same cycle as a drop -> `overflow` stays 1.
